// File: rtl/dp_bytemem_ctrl.sv
//-----------------------------------------------------------------------------
// dp_bytemem_ctrl
//   Simple-dual-port word memory with a built-in zero-fill engine.
//   Port A: write-only, per-byte write enables.
//   Port B: read-only, one-cycle registered read with a valid flag.
//   After reset, or when clear_req is seen in READY, the clear engine sweeps
//   every word to zero. While it runs it owns the array: port A writes are
//   dropped (flagged on wr_drop) and port B reads are ignored.
//
//   Optional feature macro: DP_BYTEMEM_FWD_EN
//     undefined : read-first. A same-cycle same-address read returns the old word.
//     defined   : write-forwarding. A same-cycle same-address read returns the
//                 per-lane merge of dina (enabled lanes) and the old word.
//
//   DATA_W must be a multiple of 8.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module dp_bytemem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Port A (write)
  input  logic                  ena,
  input  logic [DATA_W/8-1:0]   wea,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [DATA_W-1:0]     dina,
  // Port B (read)
  input  logic                  renb,
  input  logic [ADDR_W-1:0]     addrb,
  output logic [DATA_W-1:0]     doutb,
  output logic                  rvalidb,
  // Clear engine / status
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  wr_drop
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [DATA_W-1:0] r_doutb;
  logic              r_rvalidb;
  logic              r_wr_drop;

  logic              w_clearing;
  logic              w_wr_req;
  logic [DATA_W-1:0] w_rd_word;

  assign w_clearing = (r_state == S_CLEAR);
  assign w_wr_req   = ena & (|wea);

  assign busy    = w_clearing;
  assign doutb   = r_doutb;
  assign rvalidb = r_rvalidb;
  assign wr_drop = r_wr_drop;

  // Word presented to the port B output register (old word, or forwarded merge).
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    w_rd_word = r_mem[addrb];
`ifdef DP_BYTEMEM_FWD_EN
    if (ena && (addra == addrb)) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) w_rd_word[8*i +: 8] = dina[8*i +: 8];
      end
    end
`endif
  end

  // Clear-engine FSM: sweep address counter and CLEAR/READY state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + ADDR_W'(1);
          if (&r_clr_addr) r_state <= S_READY;  // last word being zeroed now
        end
        S_READY: begin
          if (clear_req) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
          end
        end
        default: begin
          r_state    <= S_CLEAR;
          r_clr_addr <= '0;
        end
      endcase
    end
  end

  // Port B output register and write-drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_doutb   <= '0;
      r_rvalidb <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_clearing & w_wr_req;
      r_rvalidb <= ~w_clearing & renb;
      if (!w_clearing && renb) r_doutb <= w_rd_word;
    end
  end

  // Storage array: zero-fill during CLEAR, byte-lane writes in READY.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term; it maps onto block RAM and is zeroed
    // by the clear engine sweep instead.
    if (w_clearing) begin
      r_mem[r_clr_addr] <= '0;
    end else if (ena) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) r_mem[addra][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dp_bytemem_ctrl.sv
//-----------------------------------------------------------------------------
// tb_dp_bytemem_ctrl
//   Self-checking bench for dp_bytemem_ctrl (small DEPTH for short sweeps).
//   Reference model: a plain word array plus a "sweep cycles remaining" count.
//   A sweep is modelled as zeroing the whole array the moment it starts, since
//   the array cannot be observed or written while the engine owns it.
//   Honours DP_BYTEMEM_FWD_EN the same way the design does.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dp_bytemem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic [NB-1:0]     wea = '0;
  logic [ADDR_W-1:0] addra = '0;
  logic [DATA_W-1:0] dina = '0;
  logic              renb = 1'b0;
  logic [ADDR_W-1:0] addrb = '0;
  logic [DATA_W-1:0] doutb;
  logic              rvalidb;
  logic              clear_req = 1'b0;
  logic              busy;
  logic              wr_drop;

  dp_bytemem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .renb      (renb),
    .addrb     (addrb),
    .doutb     (doutb),
    .rvalidb   (rvalidb),
    .clear_req (clear_req),
    .busy      (busy),
    .wr_drop   (wr_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_sweep_left;
  logic [DATA_W-1:0] m_dout;
  logic              m_rvalid;
  logic              m_drop;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [NB-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic model_zero_all();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  task automatic model_reset();
    model_zero_all();
    m_sweep_left = DEPTH;
    m_dout       = '0;
    m_rvalid     = 1'b0;
    m_drop       = 1'b0;
  endtask

  // One rising edge's worth of behaviour, from the current input values.
  task automatic model_edge();
    if (m_sweep_left > 0) begin
      m_drop   = ena && (wea != '0);
      m_rvalid = 1'b0;
      m_sweep_left--;
    end else begin
      m_drop   = 1'b0;
      m_rvalid = renb;
      if (renb) begin
        m_dout = m_mem[addrb];
`ifdef DP_BYTEMEM_FWD_EN
        if (ena && addra == addrb) m_dout = merge(m_dout, dina, wea);
`endif
      end
      if (ena) m_mem[addra] = merge(m_mem[addra], dina, wea);
      if (clear_req) begin
        m_sweep_left = DEPTH;
        model_zero_all();
      end
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check("busy",    DATA_W'(busy),    DATA_W'(m_sweep_left > 0));
    check("rvalidb", DATA_W'(rvalidb), DATA_W'(m_rvalid));
    check("doutb",   doutb,            m_dout);
    check("wr_drop", DATA_W'(wr_drop), DATA_W'(m_drop));
  endtask

  task automatic idle();
    ena = 1'b0; wea = '0; renb = 1'b0; clear_req = 1'b0;
  endtask

  // Clock until busy drops (bounded); return number of edges taken.
  task automatic count_busy(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 2*DEPTH);
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [NB-1:0] be,
                       input logic [DATA_W-1:0] d);
    ena = 1'b1; wea = be; addra = a; dina = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  logic [DATA_W-1:0] exp_same;

  initial begin
    model_reset();
    // ---- 1: reset, power-on sweep length, every word reads zero ----
    #1;
    check("rst_busy",    DATA_W'(busy),    1);
    check("rst_rvalidb", DATA_W'(rvalidb), 0);
    check("rst_doutb",   doutb,            0);
    check("rst_wr_drop", DATA_W'(wr_drop), 0);
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    check("t1_sweep_len", DATA_W'(n), DATA_W'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      renb = 1'b1; addrb = ADDR_W'(a);
      step();
    end
    idle();
    step();

    // ---- 2: full write then single-lane overwrite ----
    write(5, 4'b1111, 32'hDEADBEEF); step();
    write(5, 4'b0010, 32'h0000AA00); step();
    idle(); renb = 1'b1; addrb = 5;  step();
    check("t2_read", doutb, 32'hDEADAAEF);
    check("t2_rvalid", DATA_W'(rvalidb), 1);

    // ---- 3: same-cycle same-address read and write ----
    idle(); write(7, 4'b1111, 32'hAABBCCDD); step();
    write(7, 4'b0011, 32'h11223344); renb = 1'b1; addrb = 7; step();
`ifdef DP_BYTEMEM_FWD_EN
    exp_same = 32'hAABB3344;
`else
    exp_same = 32'hAABBCCDD;
`endif
    check("t3_same_cycle", doutb, exp_same);
    idle(); renb = 1'b1; addrb = 7; step();
    check("t3_next_read", doutb, 32'hAABB3344);

    // ---- random traffic in READY, small address window for collisions ----
    for (int c = 0; c < 400; c++) begin
      ena   = 1'($urandom_range(0, 1));
      wea   = NB'($urandom);
      addra = ADDR_W'($urandom_range(0, 15));
      dina  = $urandom;
      renb  = 1'($urandom_range(0, 1));
      addrb = ($urandom_range(0, 3) == 0) ? addra : ADDR_W'($urandom_range(0, 15));
      step();
    end
    idle();
    write(3, 4'b1111, 32'h12345678); step();
    idle(); step();

    // ---- 4: write during sweep is dropped, read ignored, addr 3 zeroed ----
    clear_req = 1'b1; step();
    clear_req = 1'b0; step();          // first sweep cycle
    write(3, 4'b1111, 32'hCAFEF00D); renb = 1'b1; addrb = 3;
    step();                            // second sweep cycle
    check("t4_wr_drop", DATA_W'(wr_drop), 1);
    check("t4_rvalid",  DATA_W'(rvalidb), 0);
    idle(); step();
    check("t4_drop_pulse", DATA_W'(wr_drop), 0);
    count_busy(n);
    renb = 1'b1; addrb = 3; step();
    check("t4_addr3_zero", doutb, 0);
    check("t4_addr3_valid", DATA_W'(rvalidb), 1);
    idle(); step();

    // ---- 5: reset mid-sweep restarts a full sweep ----
    clear_req = 1'b1; step();
    clear_req = 1'b0;
    repeat (100) step();               // next edge would zero address 100
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_doutb",   doutb,            0);
    check("t5_rvalidb", DATA_W'(rvalidb), 0);
    check("t5_busy",    DATA_W'(busy),    1);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    check("t5_sweep_len", DATA_W'(n), DATA_W'(DEPTH));

    // ---- 6: clear_req held through the sweep re-enters CLEAR once ----
    write(9, 4'b1111, 32'h0BADBEEF); step();
    idle(); clear_req = 1'b1; step();
    count_busy(n);
    check("t6_first_sweep", DATA_W'(n), DATA_W'(DEPTH));
    check("t6_ready_gap", DATA_W'(busy), 0);
    step();
    check("t6_reenter", DATA_W'(busy), 1);
    clear_req = 1'b0;
    count_busy(n);
    check("t6_second_sweep", DATA_W'(n), DATA_W'(DEPTH));
    renb = 1'b1; addrb = 9; step();
    check("t6_addr9_zero", doutb, 0);
    idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
